// File: rtl/tpu_host_pkg.sv
// Shared types and sizing for the TPU host driver: FSM states, row-pair layout, job depth and widths.
package tpu_host_pkg;
  localparam int DEPTH  = 32;
  localparam int WORD_W = 256;
  localparam int DIM_W  = 5;
  localparam int TMO_W  = 12;
  localparam int AW     = $clog2(DEPTH);
  localparam int IDX_W  = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {IDLE, FILL, BURST, WAIT, CAPT, DLVR} state_t;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
  } row_pair_t;
endpackage

// File: rtl/tpu_host_if.sv
// Source, accelerator and result-sink signals of the TPU host driver; master = driver side.
interface tpu_host_if;
  import tpu_host_pkg::*;

  logic              src_valid;
  logic              src_ready;
  logic [WORD_W-1:0] src_a;
  logic [WORD_W-1:0] src_b;
  logic              acc_in_valid;
  logic [WORD_W-1:0] acc_a;
  logic [WORD_W-1:0] acc_b;
  logic [DIM_W-1:0]  acc_m;
  logic [DIM_W-1:0]  acc_n;
  logic [DIM_W-1:0]  acc_k;
  logic              acc_out_valid;
  logic [WORD_W-1:0] acc_out;
  logic              res_valid;
  logic              res_ready;
  logic [WORD_W-1:0] res_data;
  logic              res_last;

  modport master (
    input  src_valid, src_a, src_b, acc_out_valid, acc_out, res_ready,
    output src_ready, acc_in_valid, acc_a, acc_b, acc_m, acc_n, acc_k,
    output res_valid, res_data, res_last
  );

  modport slave (
    output src_valid, src_a, src_b, acc_out_valid, acc_out, res_ready,
    input  src_ready, acc_in_valid, acc_a, acc_b, acc_m, acc_n, acc_k,
    input  res_valid, res_data, res_last
  );
endinterface

// File: rtl/tpu_host_ram.sv
// 1W1R row RAM with registered read data (one cycle read latency, no read enable).
module tpu_host_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/tpu_host_driver.sv
// Stages DEPTH row pairs, replays them as one gap-free burst, captures the result burst, drains it over valid/ready.
// Source and sink may stall; the accelerator cannot. Optional WAIT watchdog with tmo port: TPU_HOST_TIMEOUT_EN.
module tpu_host_driver
  import tpu_host_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_m,
  input  logic [DIM_W-1:0] cfg_n,
  input  logic [DIM_W-1:0] cfg_k,
  tpu_host_if.master       bus,
  output logic             busy,
  output logic             err
`ifdef TPU_HOST_TIMEOUT_EN
  ,
  output logic             tmo
`endif
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, cnt_q, cnt_d, rd_q, rd_d;
  logic              acc_in_valid_q, acc_in_valid_d;
  logic [WORD_W-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic [DIM_W-1:0]  acc_m_q, acc_m_d, acc_n_q, acc_n_d, acc_k_q, acc_k_d;
  logic              err_q, err_d;
  logic              stage_we, res_we;
  row_pair_t         stage_wdata, stage_rdata;
  logic [WORD_W-1:0] res_rdata;
`ifdef TPU_HOST_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2 ** TMO_W) - 2);
  logic [TMO_W-1:0]  wdog_q, wdog_d;
  logic              tmo_q, tmo_d;
`endif

  assign stage_wdata = '{a: bus.src_a, b: bus.src_b};

  // Read addresses follow the next index so RAM data lines up with the index in the following cycle.
  tpu_host_ram #(.WIDTH($bits(row_pair_t)), .DEPTH(DEPTH)) u_stage (
    .clk(clk), .wr_en(stage_we), .wr_addr(idx_q[AW-1:0]), .wr_data(stage_wdata),
    .rd_addr(idx_d[AW-1:0]), .rd_data(stage_rdata)
  );

  tpu_host_ram #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_res (
    .clk(clk), .wr_en(res_we), .wr_addr(cnt_q[AW-1:0]), .wr_data(bus.acc_out),
    .rd_addr(rd_d[AW-1:0]), .rd_data(res_rdata)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    rd_d           = rd_q;
    acc_in_valid_d = 1'b0;
    acc_a_d        = '0;
    acc_b_d        = '0;
    acc_m_d        = acc_m_q;
    acc_n_d        = acc_n_q;
    acc_k_d        = acc_k_q;
    err_d          = err_q;
    stage_we       = 1'b0;
    res_we         = 1'b0;
`ifdef TPU_HOST_TIMEOUT_EN
    wdog_d         = '0;
    tmo_d          = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_m_d = cfg_m;
          acc_n_d = cfg_n;
          acc_k_d = cfg_k;
          err_d   = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          rd_d    = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (bus.src_valid) begin
          stage_we = 1'b1;
          idx_d    = idx_q + IDX_W'(1);
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = BURST;
          end
        end
      end
      BURST: begin
        acc_in_valid_d = 1'b1;
        acc_a_d        = stage_rdata.a;
        acc_b_d        = stage_rdata.b;
        idx_d          = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.acc_out_valid) begin
          res_we  = 1'b1;
          cnt_d   = IDX_W'(1);
          state_d = CAPT;
        end
`ifdef TPU_HOST_TIMEOUT_EN
        else if (wdog_q == TMO_LAST) begin
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wdog_d = wdog_q + TMO_W'(1);
        end
`endif
      end
      CAPT: begin
        if (bus.acc_out_valid) begin
          res_we = 1'b1;
          cnt_d  = cnt_q + IDX_W'(1);
          if (cnt_q == LAST) state_d = DLVR;
        end else begin
          err_d   = 1'b1;
          state_d = DLVR;
        end
      end
      DLVR: begin
        if (bus.res_ready) begin
          rd_d = rd_q + IDX_W'(1);
          if (rd_q == LAST) begin
            rd_d    = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A stray result beat wins over the clear from a same-cycle start.
    if (bus.acc_out_valid && (state_q != WAIT) && (state_q != CAPT)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      rd_q           <= '0;
      acc_in_valid_q <= 1'b0;
      acc_a_q        <= '0;
      acc_b_q        <= '0;
      acc_m_q        <= '0;
      acc_n_q        <= '0;
      acc_k_q        <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      rd_q           <= rd_d;
      acc_in_valid_q <= acc_in_valid_d;
      acc_a_q        <= acc_a_d;
      acc_b_q        <= acc_b_d;
      acc_m_q        <= acc_m_d;
      acc_n_q        <= acc_n_d;
      acc_k_q        <= acc_k_d;
      err_q          <= err_d;
    end
  end

`ifdef TPU_HOST_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tmo_q  <= tmo_d;
    end
  end

  assign tmo = tmo_q;
`endif

  assign bus.src_ready    = (state_q == FILL);
  assign bus.acc_in_valid = acc_in_valid_q;
  assign bus.acc_a        = acc_a_q;
  assign bus.acc_b        = acc_b_q;
  assign bus.acc_m        = acc_m_q;
  assign bus.acc_n        = acc_n_q;
  assign bus.acc_k        = acc_k_q;
  assign bus.res_valid    = (state_q == DLVR);
  assign bus.res_data     = (state_q == DLVR) ? res_rdata : '0;
  assign bus.res_last     = (state_q == DLVR) && (rd_q == LAST);
  assign busy             = (state_q != IDLE);
  assign err              = err_q;
endmodule
